// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction memory server.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single write / single read instruction RAM with registered read data.
// Latency: read data one cycle after address. Backpressure: none, always accepts.
// Array is deliberately left unreset; the server masks words beyond the image.
module imem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_server.sv
// Loads a byte-serial program image into instruction RAM, then serves CPU fetches.
// Latency: fetch data registered one cycle after im_next_PC_i. Backpressure: ld_ready_o low once running.
// The CPU is held in reset until the image is complete or the RAM is full.
module imem_server
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int CW          = $clog2(DEPTH_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    input  logic [ADDR_WIDTH-1:0] im_PC_i,
    input  logic [ADDR_WIDTH-1:0] im_next_PC_i,
    output logic [DAT_WIDTH-1:0]  im_wdata_o,
    output logic                  cpu_rst_n_o,
    output logic                  load_done_o,
    output logic [CW-1:0]         load_words_o,
    output logic                  fault_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_t           state_q, state_d;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           asm_q;
    logic [CW-1:0]         words_q;
    logic                  run_q;
    logic                  ok_q;
    logic                  fault_q;

    logic                  accept;
    logic                  word_done;
    logic                  full;
    logic [31:0]           wr_word;
    logic [ADDR_WIDTH-1:0] fa;
    logic [AW-1:0]         rd_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  in_image;
    logic                  pc_bad;
    logic                  unused_pc;
    logic [31:0]           ram_rd;

    assign ld_ready_o = (state_q != RUN);
    assign accept     = ld_valid_i && ld_ready_o;
    assign word_done  = accept && ((byte_cnt_q == 2'd3) || ld_last_i);
    assign full       = word_done && (words_q == CW'(DEPTH_WORDS - 1));
    // Assembly register is cleared after every write, so upper bytes of a short word are already zero.
    assign wr_word    = asm_q | (32'(ld_byte_i) << {byte_cnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: if (accept) state_d = (ld_last_i || full) ? RUN : LOAD;
            default:    state_d = RUN;
        endcase
    end

    assign fa           = run_q ? im_next_PC_i : '0;
    assign misaligned   = |fa[1:0];
    assign out_of_range = (fa >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
    assign rd_idx       = fa[AW+1:2];
    assign in_image     = {1'b0, rd_idx} < words_q;
    assign pc_bad       = |im_PC_i[1:0];
    assign unused_pc    = ^im_PC_i[ADDR_WIDTH-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            words_q    <= '0;
            run_q      <= 1'b0;
            ok_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_q == RUN);
            ok_q    <= !misaligned && !out_of_range && in_image;
            if (run_q && (misaligned || out_of_range || pc_bad)) begin
                fault_q <= 1'b1;
            end
            if (accept) begin
                if (word_done) begin
                    asm_q      <= '0;
                    byte_cnt_q <= 2'd0;
                    words_q    <= words_q + CW'(1);
                end else begin
                    asm_q      <= wr_word;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                end
            end
        end
    end

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (word_done),
        .wr_addr (words_q[AW-1:0]),
        .wr_dat  (wr_word),
        .rd_addr (rd_idx),
        .rd_dat  (ram_rd)
    );

    // ok_q travels alongside the RAM read so stale or invalid words never reach the CPU.
    assign im_wdata_o   = ok_q ? ram_rd : NOP_INSTR;
    assign cpu_rst_n_o  = run_q;
    assign load_done_o  = run_q;
    assign load_words_o = words_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench: fetch expectations go through a scoreboard queue checked by a monitor.
module tb_imem_server;

    localparam int AW_T  = 32;
    localparam int DEPTH = 16;
    localparam int CW_T  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld_valid = 1'b0;
    logic [7:0]      ld_byte = 8'h00;
    logic            ld_last = 1'b0;
    logic            ld_ready;
    logic [AW_T-1:0] im_pc = '0;
    logic [AW_T-1:0] im_next_pc = '0;
    logic [31:0]     im_wdata;
    logic            cpu_rst_n;
    logic            load_done;
    logic [CW_T-1:0] load_words;
    logic            fault;

    int errors = 0;
    int checks = 0;

    logic        fetch_vld = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] exp_q [$];

    imem_server #(
        .ADDR_WIDTH  (AW_T),
        .DAT_WIDTH   (32),
        .DEPTH_WORDS (DEPTH),
        .CW          (CW_T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid_i   (ld_valid),
        .ld_byte_i    (ld_byte),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .im_PC_i      (im_pc),
        .im_next_PC_i (im_next_pc),
        .im_wdata_o   (im_wdata),
        .cpu_rst_n_o  (cpu_rst_n),
        .load_done_o  (load_done),
        .load_words_o (load_words),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a fetch issued before a rising edge is checked at the following falling edge.
    always @(posedge clk) pend <= fetch_vld;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_underflow: got %h expected none", im_wdata);
            end else begin
                chk("fetch_data", im_wdata, exp_q.pop_front());
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_end();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
        im_next_pc = pc;
        fetch_vld  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_end();
        fetch_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        fetch_vld = 1'b0;
        im_next_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_wdata", im_wdata, NOP);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_words", 32'(load_words), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] img1 [8];
        int bad;
        img1 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};

        @(negedge clk);
        do_reset();

        // Idle with no load traffic: CPU stays held, output stays NOP.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_rst_n !== 1'b0 || im_wdata !== NOP) bad++;
        end
        chk("idle_hold_bad_cycles", 32'(bad), 32'd0);

        // Two-word image, last on the 8th byte.
        for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
        load_end();
        chk("t1_load_words", 32'(load_words), 32'd2);
        chk("t1_ld_ready_low", 32'(ld_ready), 32'd0);
        chk("t1_cpu_still_held", 32'(cpu_rst_n), 32'd0);
        fetch(32'd0, 32'h00A0_0513);
        chk("t1_cpu_released", 32'(cpu_rst_n), 32'd1);
        chk("t1_load_done", 32'(load_done), 32'd1);
        fetch(32'd4, 32'h00B0_0593);
        fetch(32'd8, NOP);
        fetch_end();
        chk("t1_fault_clear", 32'(fault), 32'd0);

        // Six-byte image: second word padded with zeros.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(img1[i], 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        load_end();
        chk("t2_load_words", 32'(load_words), 32'd2);
        fetch(32'd0, 32'h00A0_0513);
        fetch(32'd4, 32'h0000_2211);
        fetch(32'd8, NOP);
        fetch_end();
        chk("t2_beyond_image_no_fault", 32'(fault), 32'd0);
        fetch(32'd6, NOP);
        fetch_end();
        chk("t2_misaligned_fault", 32'(fault), 32'd1);
        fetch(32'd0, 32'h00A0_0513);
        fetch_end();
        chk("t2_fault_sticky", 32'(fault), 32'd1);

        // Fill the RAM without ld_last.
        do_reset();
        for (int i = 0; i < DEPTH * 4; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == DEPTH * 4 - 2) chk("t3_ready_before_full", 32'(ld_ready), 32'd1);
        end
        load_end();
        chk("t3_ready_after_full", 32'(ld_ready), 32'd0);
        chk("t3_load_words_full", 32'(load_words), 32'(DEPTH));
        send_byte(8'hEE, 1'b1);
        load_end();
        chk("t3_ignored_after_full", 32'(load_words), 32'(DEPTH));
        fetch(32'd0, 32'h0302_0100);
        fetch(32'd60, 32'h3F3E_3D3C);
        fetch(32'(DEPTH * 4), NOP);
        fetch_end();
        chk("t3_range_fault", 32'(fault), 32'd1);
        fetch(32'd0, 32'h0302_0100);
        fetch_end();
        chk("t3_fault_sticky", 32'(fault), 32'd1);

        // Reset in the middle of a word, then a fresh one-word image.
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        do_reset();
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b1);
        load_end();
        chk("t4_load_words", 32'(load_words), 32'd1);
        fetch(32'd0, 32'h1234_5678);
        fetch(32'd4, NOP);
        fetch_end();
        chk("t4_fault_clear", 32'(fault), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
